// File: rtl/addmw_seq.sv
// Multi-word add/subtract sequencer: one 32-bit adder reused over WORDS cycles,
// LSW first, with a registered carry chained between words and valid/ready on both sides.

module fulladder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] s_o,
    output logic        c_o
);
    assign {c_o, s_o} = 33'(a_i) + 33'(b_i) + 33'(c_i);
endmodule

module addmw_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [32*WORDS-1:0]   a_i,
    input  logic [32*WORDS-1:0]   b_i,
    input  logic                  carry_i,
    input  logic                  sub_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [32*WORDS-1:0]   sum_o,
    output logic                  carry_o,
    output logic                  ovf_o,
    output logic                  busy_o
);
    localparam int unsigned W  = 32 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic [31:0]   a_word;
    logic [31:0]   b_raw;
    logic [31:0]   b_word;
    logic [31:0]   add_sum;
    logic          add_cout;
    logic          last_word;

    // Select the current operand word; B is inverted for subtraction
    always_comb begin
        a_word = '0;
        b_raw  = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (idx_q == IW'(k)) begin
                a_word = a_q[32*k +: 32];
                b_raw  = b_q[32*k +: 32];
            end
        end
        b_word    = sub_q ? ~b_raw : b_raw;
        last_word = (idx_q == IW'(WORDS - 1));
    end

    fulladder32 u_add (
        .a_i (a_word),
        .b_i (b_word),
        .c_i (carry_q),
        .s_o (add_sum),
        .c_o (add_cout)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_i;
                    idx_d   = '0;
                    carry_d = sub_i ? 1'b1 : carry_i;
                end
            end
            S_RUN: begin
                for (int unsigned k = 0; k < WORDS; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[32*k +: 32] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (last_word) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    cout_d  = add_cout;
                    // Overflow: operands agree in sign but the result does not
                    ovf_d   = (a_q[W-1] == b_word[31]) && (add_sum[31] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (valid_q && ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = cout_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = busy_q;

endmodule
